// File: rtl/wb_slave_ram_pkg.sv
// Shared definitions for the Wishbone slave RAM: cycle-type codes, wait
// counter sizing and the one-hot FSM state encoding.
package wb_slave_pkg;

    // Wishbone B4 cycle type identifiers carried on s_cti_i
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // The wait counter covers 0..15 extra cycles before the first ack
    localparam int WCNT_W          = 4;
    localparam int MAX_WAIT_STATES = 15;

    // One-hot state encoding; one bit per FSM state
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_WAIT  = 4'b0010,
        ST_ACK   = 4'b0100,
        ST_BURST = 4'b1000
    } state_t;

    // Only the incrementing-burst code opens a multi-beat transfer;
    // every other code is served as a single classic beat.
    function automatic logic isIncrBurst(input logic [2:0] cti);
        return cti == CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_slave_ram_if.sv
// Wishbone B4 bus bundle between a master and the slave RAM.
// Signal names are seen from the slave side (_i into the slave, _o out of it).
interface wb_slave_ram_if #(
    parameter int DW   = 32,
    parameter int Aw   = 7,
    parameter int SELw = 4,
    parameter int TAGw = 3
);

    logic [DW-1:0]   s_dat_i;
    logic [SELw-1:0] s_sel_i;
    logic [Aw-1:0]   s_addr_i;
    logic [TAGw-1:0] s_cti_i;
    logic            s_stb_i;
    logic            s_cyc_i;
    logic            s_we_i;
    logic [DW-1:0]   s_dat_o;
    logic            s_ack_o;

    modport master (
        output s_dat_i, s_sel_i, s_addr_i, s_cti_i, s_stb_i, s_cyc_i, s_we_i,
        input  s_dat_o, s_ack_o
    );

    modport slave (
        input  s_dat_i, s_sel_i, s_addr_i, s_cti_i, s_stb_i, s_cyc_i, s_we_i,
        output s_dat_o, s_ack_o
    );

endinterface

// File: rtl/wb_slave_ram_core.sv
// Single-port word RAM with per-byte-lane write enables and a registered
// read port. No reset, so synthesis can map it onto block RAM. The read is
// read-first: a read and write at the same address return the old word.
module wb_slave_ram_core #(
    parameter int DW   = 32,
    parameter int Aw   = 7,
    parameter int SELw = 4
) (
    input  logic            clk,
    input  logic [SELw-1:0] i_we,
    input  logic            i_re,
    input  logic [Aw-1:0]   i_addr,
    input  logic [DW-1:0]   i_wdata,
    output logic [DW-1:0]   o_rdata
);

    localparam int DEPTH = 2 ** Aw;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Byte-lane writes: only the lanes whose enable bit is set are updated
    always_ff @(posedge clk) begin
        for (int n = 0; n < SELw; n++) begin
            if (i_we[n]) begin
                r_mem[i_addr][n*8 +: 8] <= i_wdata[n*8 +: 8];
            end
        end
    end

    // Registered read port, loaded only when a read is requested
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_slave_ram.sv
// Wishbone B4 slave in front of a byte-writable RAM. Serves classic single
// cycles (the JTAG debug master) and incrementing bursts, with a fixed
// number of wait states inserted before the first ack of every cycle.
module wb_slave_ram
    import wb_slave_pkg::*;
#(
    parameter int          DW          = 32,
    parameter int          Aw          = 7,
    parameter int          SELw        = 4,
    parameter int          TAGw        = 3,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          reset,
    wb_slave_ram_if.slave bus
);

    // Anything above the counter range is clamped rather than wrapped
    localparam int WS_EFF = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : int'(WAIT_STATES);
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WS_EFF);

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_ackQ;
    logic              w_ackNext;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcntNext;
    logic [Aw-1:0]     r_baddr;
    logic [Aw-1:0]     w_baddrNext;
    logic [Aw-1:0]     w_baddrInc;
    logic              r_datZero;

    logic              w_req;
    logic              w_ack;
    logic [TAGw-1:0]   w_cti;
    logic              w_doWrite;
    logic              w_doRead;
    logic [Aw-1:0]     w_ramAddr;
    logic [SELw-1:0]   w_ramWe;
    logic              w_ramRe;
    logic [DW-1:0]     w_ramRdata;

    assign w_req      = bus.s_stb_i & bus.s_cyc_i;
    assign w_ack      = r_ackQ & w_req;
    assign w_cti      = bus.s_cti_i;
    assign w_baddrInc = r_baddr + 1'b1;

    // Reset must suppress any write or read scheduled for the same edge
    assign w_ramWe = (w_doWrite && !reset) ? bus.s_sel_i : '0;
    assign w_ramRe = w_doRead && !reset;

    // The RAM read port has no reset, so the output is forced to zero until
    // the first read after reset reloads it.
    assign bus.s_dat_o = r_datZero ? '0 : w_ramRdata;
    assign bus.s_ack_o = w_ack;

    wb_slave_ram_core #(
        .DW   (DW),
        .Aw   (Aw),
        .SELw (SELw)
    ) u_core (
        .clk     (clk),
        .i_we    (w_ramWe),
        .i_re    (w_ramRe),
        .i_addr  (w_ramAddr),
        .i_wdata (bus.s_dat_i),
        .o_rdata (w_ramRdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Ack flag, wait counter, burst address and output-zero flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ackQ    <= 1'b0;
            r_wcnt    <= '0;
            r_datZero <= 1'b1;
        end else begin
            r_ackQ  <= w_ackNext;
            r_wcnt  <= w_wcntNext;
            r_baddr <= w_baddrNext;
            if (w_ramRe) begin
                r_datZero <= 1'b0;
            end
        end
    end

    // Next state, RAM port control and register updates for each FSM state
    always_comb begin
        w_stateNext = r_state;
        w_ackNext   = r_ackQ;
        w_wcntNext  = r_wcnt;
        w_baddrNext = r_baddr;
        w_doWrite   = 1'b0;
        w_doRead    = 1'b0;
        w_ramAddr   = r_baddr;

        unique case (r_state)
            ST_IDLE: begin
                // The address register is not loaded yet, so a zero-wait
                // cycle reads straight from the bus address.
                w_ramAddr = bus.s_addr_i;
                if (w_req) begin
                    w_baddrNext = bus.s_addr_i;
                    w_wcntNext  = WCNT_LOAD;
                    if (WS_EFF == 0) begin
                        w_doRead    = 1'b1;
                        w_ackNext   = 1'b1;
                        w_stateNext = isIncrBurst(w_cti) ? ST_BURST : ST_ACK;
                    end else begin
                        w_stateNext = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                w_wcntNext = r_wcnt - 1'b1;
                if (!w_req) begin
                    // Master gave up during the wait: abandon without writing
                    w_wcntNext  = '0;
                    w_stateNext = ST_IDLE;
                end else if (r_wcnt <= 1) begin
                    // Counter reaches zero on this edge: present data and ack
                    w_doRead    = 1'b1;
                    w_ackNext   = 1'b1;
                    w_stateNext = isIncrBurst(w_cti) ? ST_BURST : ST_ACK;
                end
            end

            ST_ACK: begin
                w_doWrite   = w_ack & bus.s_we_i;
                w_ackNext   = 1'b0;
                w_stateNext = ST_IDLE;
            end

            ST_BURST: begin
                if (!w_req) begin
                    w_ackNext   = 1'b0;
                    w_stateNext = ST_IDLE;
                end else begin
                    // Write this beat at the current address, then advance;
                    // reads prefetch the next word so data is ready each beat.
                    w_doWrite   = w_ack & bus.s_we_i;
                    w_baddrNext = w_baddrInc;
                    if (!bus.s_we_i) begin
                        w_doRead  = 1'b1;
                        w_ramAddr = w_baddrInc;
                    end
                    if (!isIncrBurst(w_cti)) begin
                        w_ackNext   = 1'b0;
                        w_stateNext = ST_IDLE;
                    end
                end
            end

            default: begin
                w_ackNext   = 1'b0;
                w_stateNext = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_slave_ram.sv
// Bench for wb_slave_ram: two instances (0 and 3 wait states) share one
// master driver; a byte-level reference memory predicts every read.
module tb_wb_slave_ram;
    import wb_slave_pkg::*;

    localparam int CYCLE_BUDGET = 40;

    logic        clk;
    logic        reset;
    int          target;
    logic        mStb, mCyc, mWe;
    logic [6:0]  mAddr;
    logic [31:0] mDat;
    logic [3:0]  mSel;
    logic [2:0]  mCti;
    logic        wAck;
    logic [31:0] wDat;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0]  refBytes [2][512];
    logic [31:0] beatData [8];
    logic [31:0] beatRd   [8];
    int          beatAck  [8];

    wb_slave_ram_if #(.DW(32), .Aw(7), .SELw(4), .TAGw(3)) bus0 ();
    wb_slave_ram_if #(.DW(32), .Aw(7), .SELw(4), .TAGw(3)) bus3 ();

    wb_slave_ram #(.DW(32), .Aw(7), .SELw(4), .TAGw(3), .WAIT_STATES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    wb_slave_ram #(.DW(32), .Aw(7), .SELw(4), .TAGw(3), .WAIT_STATES(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    // Only the targeted instance sees the strobe; the other stays idle
    assign bus0.s_stb_i  = mStb & (target == 0);
    assign bus3.s_stb_i  = mStb & (target == 1);
    assign bus0.s_cyc_i  = mCyc;
    assign bus3.s_cyc_i  = mCyc;
    assign bus0.s_we_i   = mWe;
    assign bus3.s_we_i   = mWe;
    assign bus0.s_addr_i = mAddr;
    assign bus3.s_addr_i = mAddr;
    assign bus0.s_dat_i  = mDat;
    assign bus3.s_dat_i  = mDat;
    assign bus0.s_sel_i  = mSel;
    assign bus3.s_sel_i  = mSel;
    assign bus0.s_cti_i  = mCti;
    assign bus3.s_cti_i  = mCti;
    assign wAck = (target == 0) ? bus0.s_ack_o : bus3.s_ack_o;
    assign wDat = (target == 0) ? bus0.s_dat_o : bus3.s_dat_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and count it
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int waitStatesOf(input int t);
        return (t == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] modelRead(input int t, input logic [6:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = refBytes[t][int'(a) * 4 + k];
        return w;
    endfunction

    task automatic modelWrite(input int t, input logic [6:0] a, input logic [31:0] d, input logic [3:0] sel);
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) refBytes[t][int'(a) * 4 + k] = d[k*8 +: 8];
        end
    endtask

    function automatic logic [2:0] ctiFor(input int beat, input int n);
        if (n == 1) return CTI_CLASSIC;
        if (beat == n - 1) return CTI_EOB;
        return CTI_INCR;
    endfunction

    // One master transaction of n beats; holds the request one cycle past
    // the last ack to prove the ack does not linger, then checks timing/data.
    task automatic applyStimulus(input int t, input bit we, input logic [6:0] addr, input int n, input logic [3:0] sel);
        int beat;
        int cyc;
        target = t;
        @(posedge clk); #1;
        mCyc = 1'b1; mStb = 1'b1; mWe = we; mSel = sel;
        mAddr = addr; mDat = beatData[0]; mCti = ctiFor(0, n);
        beat = 0;
        cyc  = 0;
        while (beat < n && cyc < CYCLE_BUDGET) begin
            @(negedge clk);
            if (wAck === 1'b1) begin
                beatAck[beat] = cyc;
                beatRd[beat]  = wDat;
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
            if (beat < n) begin
                mAddr = 7'(addr + beat);
                mDat  = beatData[beat];
                mCti  = ctiFor(beat, n);
            end
        end
        checkOutput("beatsAcked", beat, n);
        if (beat == n) begin
            @(negedge clk);
            checkOutput("ackAfterLast", 32'(wAck), 32'd0);
            @(posedge clk); #1;
        end
        mStb = 1'b0; mCyc = 1'b0; mWe = 1'b0; mSel = 4'h0; mCti = CTI_CLASSIC;
        for (int i = 0; i < beat; i++) begin
            checkOutput("ackCycle", beatAck[i], 1 + waitStatesOf(t) + i);
            if (we) modelWrite(t, 7'(addr + i), beatData[i], sel);
            else    checkOutput("readData", beatRd[i], modelRead(t, 7'(addr + i)));
        end
    endtask

    task automatic writeWord(input int t, input logic [6:0] a, input logic [31:0] d, input logic [3:0] sel);
        beatData[0] = d;
        applyStimulus(t, 1'b1, a, 1, sel);
    endtask

    task automatic readWord(input int t, input logic [6:0] a);
        beatData[0] = 32'h0;
        applyStimulus(t, 1'b0, a, 1, 4'hF);
    endtask

    // An ack must never appear without a live request on either instance
    always @(negedge clk) begin
        if (!(bus0.s_stb_i & bus0.s_cyc_i)) checkOutput("ackNoReq0", 32'(bus0.s_ack_o), 32'd0);
        if (!(bus3.s_stb_i & bus3.s_cyc_i)) checkOutput("ackNoReq3", 32'(bus3.s_ack_o), 32'd0);
    end

    initial begin
        reset = 1'b1; target = 0;
        mStb = 1'b0; mCyc = 1'b0; mWe = 1'b0; mAddr = '0; mDat = '0; mSel = '0; mCti = CTI_CLASSIC;
        for (int t = 0; t < 2; t++) for (int b = 0; b < 512; b++) refBytes[t][b] = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("resetDat0", bus0.s_dat_o, 32'h0);
        checkOutput("resetDat3", bus3.s_dat_o, 32'h0);

        $display("[TB] classic cycles, no wait states");
        writeWord(0, 7'h05, 32'hDEADBEEF, 4'hF);
        readWord(0, 7'h05);
        checkOutput("readFull", beatRd[0], 32'hDEADBEEF);
        writeWord(0, 7'h05, 32'h000000AA, 4'h1);
        readWord(0, 7'h05);
        checkOutput("readLane0", beatRd[0], 32'hDEADBEAA);
        writeWord(0, 7'h05, 32'h12345678, 4'h0);
        readWord(0, 7'h05);
        checkOutput("readSelZero", beatRd[0], 32'hDEADBEAA);

        $display("[TB] wrapping bursts, no wait states");
        for (int i = 0; i < 4; i++) beatData[i] = 32'(i + 1);
        applyStimulus(0, 1'b1, 7'h7E, 4, 4'hF);
        applyStimulus(0, 1'b0, 7'h7E, 4, 4'hF);
        for (int i = 0; i < 4; i++) checkOutput("burstRd", beatRd[i], 32'(i + 1));

        $display("[TB] three wait states");
        writeWord(1, 7'h05, 32'hCAFEF00D, 4'hF);
        readWord(1, 7'h05);
        checkOutput("readWait", beatRd[0], 32'hCAFEF00D);
        target = 1;
        @(posedge clk); #1;
        mCyc = 1'b1; mStb = 1'b1; mWe = 1'b1; mAddr = 7'h05; mDat = 32'h12345678; mSel = 4'hF; mCti = CTI_CLASSIC;
        @(negedge clk); checkOutput("abortAckC0", 32'(wAck), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); checkOutput("abortAckC1", 32'(wAck), 32'd0);
        @(posedge clk); #1;
        mStb = 1'b0;
        repeat (6) @(negedge clk);
        mCyc = 1'b0; mWe = 1'b0; mSel = 4'h0;
        readWord(1, 7'h05);
        checkOutput("abortNoWrite", beatRd[0], 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) beatData[i] = 32'hA0 + 32'(i);
        applyStimulus(1, 1'b1, 7'h7E, 4, 4'hF);
        applyStimulus(1, 1'b0, 7'h7E, 4, 4'hF);
        for (int i = 0; i < 4; i++) checkOutput("burstRdWait", beatRd[i], 32'hA0 + 32'(i));

        $display("[TB] reset during wait and during ack");
        writeWord(1, 7'h07, 32'h11111111, 4'hF);
        readWord(1, 7'h07);
        target = 1;
        @(posedge clk); #1;
        mCyc = 1'b1; mStb = 1'b1; mWe = 1'b1; mAddr = 7'h07; mDat = 32'h0BADF00D; mSel = 4'hF; mCti = CTI_CLASSIC;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstWaitAck", 32'(wAck), 32'd0);
        checkOutput("rstWaitDat", wDat, 32'h0);
        @(posedge clk); #1;
        mStb = 1'b0; mCyc = 1'b0; mWe = 1'b0; mSel = 4'h0;
        readWord(1, 7'h07);
        checkOutput("rstWaitNoWrite", beatRd[0], 32'h11111111);

        writeWord(0, 7'h09, 32'h22222222, 4'hF);
        readWord(0, 7'h09);
        target = 0;
        @(posedge clk); #1;
        mCyc = 1'b1; mStb = 1'b1; mWe = 1'b1; mAddr = 7'h09; mDat = 32'h33333333; mSel = 4'hF; mCti = CTI_CLASSIC;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstAckBefore", 32'(wAck), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstAckAfter", 32'(wAck), 32'd0);
        checkOutput("rstDatAfter", wDat, 32'h0);
        @(posedge clk); #1;
        mStb = 1'b0; mCyc = 1'b0; mWe = 1'b0; mSel = 4'h0;
        readWord(0, 7'h09);
        checkOutput("rstAckNoWrite", beatRd[0], 32'h22222222);

        $display("[TB] random classic cycles against reference memory");
        for (int t = 0; t < 2; t++) begin
            for (int a = 32; a < 48; a++) writeWord(t, 7'(a), $urandom, 4'hF);
        end
        repeat (120) begin
            int t;
            logic [6:0] a;
            t = int'($urandom_range(0, 1));
            a = 7'(32 + $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) writeWord(t, a, $urandom, 4'($urandom_range(0, 15)));
            else                           readWord(t, a);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
